alu_share_arbiter: RTL

//   Shares one ALU instance between two requesters: req0 = execute stage, req1 = branch/address unit.

---
 rtl/alu_arb_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/alu_share_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU share arbiter: FSM state encoding, ALU opcode map
// and the opcode legality helper.
package alu_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_EXEC = ST_EXEC,
      S_RESP = ST_RESP
   } state_t;

   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_SUB = 5'd1;
   localparam logic [4:0] OP_AND = 5'd2;
   localparam logic [4:0] OP_OR  = 5'd3;
   localparam logic [4:0] OP_SLL = 5'd4;
   localparam logic [4:0] OP_SRA = 5'd5;
   localparam int         MAX_OP = 5;

   function automatic logic is_illegal(input logic [31:0] opcode, input logic [31:0] max_op);
      return (opcode > max_op);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a contended cycle goes to
// the requester that did not win last time.
module rr_arbiter2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);

   // Grant selection from the current request vector and the previous winner.
   always_comb begin
      grant_valid = |valid;
      grant_id    = 1'b0;
      case (valid)
         2'b01:   grant_id = 1'b0;
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~last_grant;
         default: grant_id = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external ALU between the execute stage (req0) and the
// branch/address unit (req1). Define ALU_ARB_FLAGS_EN to return the ALU ne/lt flags.
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int W      = 32,
   parameter int OPW    = 5,
   parameter int MAX_OP = alu_arb_pkg::MAX_OP
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [W-1:0]   req0_opA,
   input  logic [W-1:0]   req0_opB,
   input  logic [OPW-1:0] req0_opcode,
   input  logic [4:0]     req0_shamt,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [W-1:0]   req1_opA,
   input  logic [W-1:0]   req1_opB,
   input  logic [OPW-1:0] req1_opcode,
   input  logic [4:0]     req1_shamt,
   output logic           rsp0_valid,
   input  logic           rsp0_ready,
   output logic [W-1:0]   rsp0_result,
   output logic           rsp0_ne,
   output logic           rsp0_lt,
   output logic           rsp0_illegal,
   output logic           rsp1_valid,
   input  logic           rsp1_ready,
   output logic [W-1:0]   rsp1_result,
   output logic           rsp1_ne,
   output logic           rsp1_lt,
   output logic           rsp1_illegal,
   output logic [W-1:0]   alu_opA,
   output logic [W-1:0]   alu_opB,
   output logic [OPW-1:0] alu_opcode,
   output logic [4:0]     alu_shamt,
   input  logic [W-1:0]   alu_result,
   input  logic           alu_ne,
   input  logic           alu_lt
);

   state_t         state_r, state_s;
   logic           last_grant_r, id_r;
   logic           grant_valid_s, grant_id_s;
   logic           accept_s, pop_s, illegal_s;
   logic [W-1:0]   opa_r, opb_r, rsp_result_r;
   logic [OPW-1:0] opcode_r;
   logic [4:0]     shamt_r;
   logic           rsp_illegal_r;
   logic           rsp_ne_s, rsp_lt_s;
   logic           rsp0_valid_s, rsp1_valid_s;

   rr_arbiter2 u_rr (
      .valid       ({req1_valid, req0_valid}),
      .last_grant  (last_grant_r),
      .grant_valid (grant_valid_s),
      .grant_id    (grant_id_s)
   );

   // Ready is gated by reset so no handshake can complete while the state is being cleared.
   assign accept_s   = reset && (state_r == S_IDLE) && grant_valid_s;
   assign req0_ready = accept_s && !grant_id_s;
   assign req1_ready = accept_s && grant_id_s;
   assign pop_s      = (state_r == S_RESP) && (id_r ? rsp1_ready : rsp0_ready);
   assign illegal_s  = is_illegal(32'(opcode_r), 32'(MAX_OP));

   // Next-state logic for the IDLE -> EXEC -> RESP cycle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: if (accept_s) state_s = S_EXEC; else state_s = S_IDLE;
         S_EXEC: state_s = S_RESP;
         S_RESP: if (pop_s) state_s = S_IDLE; else state_s = S_RESP;
         default: state_s = S_IDLE;
      endcase
   end

   // State, grant history, ALU operand latches and response capture.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r       <= S_IDLE;
         last_grant_r  <= 1'b1;
         id_r          <= 1'b0;
         opa_r         <= '0;
         opb_r         <= '0;
         opcode_r      <= '0;
         shamt_r       <= 5'd0;
         rsp_result_r  <= '0;
         rsp_illegal_r <= 1'b0;
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            id_r         <= grant_id_s;
            last_grant_r <= grant_id_s;
            opa_r        <= grant_id_s ? req1_opA    : req0_opA;
            opb_r        <= grant_id_s ? req1_opB    : req0_opB;
            opcode_r     <= grant_id_s ? req1_opcode : req0_opcode;
            shamt_r      <= grant_id_s ? req1_shamt  : req0_shamt;
         end
         // An illegal opcode leaves the ALU bus undriven, so its value is never captured.
         if (state_r == S_EXEC) begin
            rsp_result_r  <= illegal_s ? '0 : alu_result;
            rsp_illegal_r <= illegal_s;
         end
      end
   end

`ifdef ALU_ARB_FLAGS_EN
   logic rsp_ne_r, rsp_lt_r;

   // Flag capture shares the EXEC timing of the result register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rsp_ne_r <= 1'b0;
         rsp_lt_r <= 1'b0;
      end else if (state_r == S_EXEC) begin
         rsp_ne_r <= !illegal_s && alu_ne;
         rsp_lt_r <= !illegal_s && alu_lt;
      end
   end

   assign rsp_ne_s = rsp_ne_r;
   assign rsp_lt_s = rsp_lt_r;
`else
   logic unused_flags_s;
   assign unused_flags_s = alu_ne ^ alu_lt;
   assign rsp_ne_s       = 1'b0;
   assign rsp_lt_s       = 1'b0;
`endif

   assign rsp0_valid_s = (state_r == S_RESP) && !id_r;
   assign rsp1_valid_s = (state_r == S_RESP) && id_r;

   assign rsp0_valid   = rsp0_valid_s;
   assign rsp0_result  = rsp0_valid_s ? rsp_result_r : '0;
   assign rsp0_ne      = rsp0_valid_s && rsp_ne_s;
   assign rsp0_lt      = rsp0_valid_s && rsp_lt_s;
   assign rsp0_illegal = rsp0_valid_s && rsp_illegal_r;

   assign rsp1_valid   = rsp1_valid_s;
   assign rsp1_result  = rsp1_valid_s ? rsp_result_r : '0;
   assign rsp1_ne      = rsp1_valid_s && rsp_ne_s;
   assign rsp1_lt      = rsp1_valid_s && rsp_lt_s;
   assign rsp1_illegal = rsp1_valid_s && rsp_illegal_r;

   assign alu_opA    = opa_r;
   assign alu_opB    = opb_r;
   assign alu_opcode = opcode_r;
   assign alu_shamt  = shamt_r;

endmodule
